vga_capture: RTL and testbench

Pixel-stream receiver for the VGA video path: samples the `hsync`, `vsync` and `rgb` signals produced by the pong top level and recovers the pixel coordinates that generated them. It runs in the same `clk` domain as the generator and advances on the shared pixel strobe. It locks to the sync pulses, re-creates `pixel_x` and `pixel_y`, emits one strobe per visible pixel, and flags any sync-timing violation. It is the bench-side and on-chip monitor counterpart to the VGA transmitter.

---
 rtl/vga_capture_pkg.sv | 22 ++
 rtl/vga_capture_sync_edge_det.sv | 23 ++
 rtl/vga_capture.sv | 160 ++++++++++++++++
 tb/tb_vga_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_capture_pkg.sv
// Shared 640x480 VGA timing constants and capture FSM state encoding.
package vga_capture_pkg;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/vga_capture_sync_edge_det.sv
// Samples one sync line on the pixel strobe and flags its leading edge.
module sync_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic p_tick,
    input  logic level,
    output logic lead
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset_n)
            prev <= ~POL;
        else if (p_tick)
            prev <= level;
    end

    assign lead = p_tick && (level == POL) && (prev != POL);

endmodule

// File: rtl/vga_capture.sv
// VGA stream receiver: locks to hsync/vsync, rebuilds pixel coordinates,
// strobes visible pixels and counts sync-timing violations.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int   HD       = H_VIS,
    parameter int   HF       = H_FP,
    parameter int   HR       = H_SYNC,
    parameter int   HB       = H_BP,
    parameter int   VD       = V_VIS,
    parameter int   VF       = V_FP,
    parameter int   VR       = V_SYNC,
    parameter int   VB       = V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [7:0] err_cnt
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    localparam logic [9:0] H_LAST = 10'(HT - 1);
    localparam logic [9:0] V_LAST = 10'(VT - 1);
    localparam logic [9:0] H_LOAD = 10'(HD + HF);
    localparam logic [9:0] V_LOAD = 10'(VD + VF);
    localparam logic [9:0] H_END  = 10'(HD);
    localparam logic [9:0] V_END  = 10'(VD);

    state_t     state;
    state_t     state_next;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_adv;
    logic [9:0] v_adv;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_lead;
    logic       v_lead;
    logic       h_wrap;
    logic       h_err;
    logic       v_err;
    logic       viol;
    logic       vis;

    sync_edge_det #(.POL(SYNC_POL)) u_hedge (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick),
        .level   (hsync),
        .lead    (h_lead)
    );

    sync_edge_det #(.POL(SYNC_POL)) u_vedge (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick),
        .level   (vsync),
        .lead    (v_lead)
    );

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_adv  = h_wrap ? '0 : h_cnt + 10'd1;
        v_adv  = v_cnt;
        if (h_wrap)
            v_adv = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= SEARCH;
        else
            state <= state_next;
    end

    // An edge and the expected count must agree in both directions.
    always_comb begin
        state_next = state;
        h_next     = h_adv;
        v_next     = v_adv;
        h_err = p_tick && (state != SEARCH)
              && (h_lead != (h_adv == H_LOAD));
        v_err = p_tick && (state == LOCKED)
              && (v_lead != (h_wrap && v_adv == V_LOAD));
        viol  = h_err || v_err;
        unique case (state)
            SEARCH: begin
                if (h_lead) begin
                    h_next     = H_LOAD;
                    state_next = HLOCK;
                end
            end
            HLOCK: begin
                if (h_err) begin
                    state_next = SEARCH;
                end else if (v_lead) begin
                    v_next     = V_LOAD;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (viol)
                    state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
        if (!p_tick) begin
            state_next = state;
            h_next     = h_cnt;
            v_next     = v_cnt;
        end
    end

    always_comb begin
        locked = (state == LOCKED);
        vis    = p_tick && (state == LOCKED) && !viol
               && (h_next < H_END) && (v_next < V_END);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            pix_valid   <= vis;
            frame_start <= vis && (h_next == '0) && (v_next == '0);
            sync_err    <= viol;
            if (viol && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            if (vis) begin
                pix_x   <= h_next;
                pix_y   <= v_next;
                pix_rgb <= rgb;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a reduced 16x12 raster so whole
// frames fit in a short run.
module tb_vga_capture;

    localparam int HD = 8;
    localparam int HF = 2;
    localparam int HR = 3;
    localparam int HB = 3;
    localparam int VD = 6;
    localparam int VF = 2;
    localparam int VR = 2;
    localparam int VB = 2;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam logic POL = 1'b1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       p_tick = 1'b0;
    logic       hsync = ~POL;
    logic       vsync = ~POL;
    logic [2:0] rgb = '0;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] pix_rgb;
    logic       frame_start;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_cnt;

    int   total = 0;
    int   bad = 0;
    int   gh = 0;
    int   gv = 0;
    int   s_h = 0;
    int   s_v = 0;
    logic inj_h = 1'b0;
    logic ovr_h = 1'b0;
    logic sup_v = 1'b0;

    always #5 clk = ~clk;

    vga_capture #(
        .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_tick      (p_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    // One generator pixel: drive, strobe, sample registered outputs, advance.
    task automatic tick();
        logic hs;
        hs = (gh >= HD + HF) && (gh < HD + HF + HR);
        if (ovr_h)
            hs = inj_h;
        else if (inj_h)
            hs = 1'b1;
        hsync  = hs ? POL : ~POL;
        vsync  = ((gv >= VD + VF) && (gv < VD + VF + VR) && !sup_v)
               ? POL : ~POL;
        rgb    = 3'(gh);
        s_h    = gh;
        s_v    = gv;
        p_tick = 1'b1;
        @(posedge clk);
        #1;
        p_tick = 1'b0;
        gh = gh + 1;
        if (gh == HT) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        p_tick  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_gen(input int h, input int v);
        int n;
        n = 0;
        while (!(gh == h && gv == v) && n < 2 * HT * VT) begin
            tick();
            n++;
        end
        total++;
        if (n >= 2 * HT * VT) begin
            bad++;
            $display("FAIL wait_gen timeout got=%0d,%0d want=%0d,%0d", gh, gv, h, v);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", pix_valid); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", frame_start); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", sync_err); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", err_cnt); end
        total++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin bad++; $display("FAIL rst_xy got=%0d,%0d want=0,0", pix_x, pix_y); end
        total++; if (pix_rgb !== 3'd0) begin bad++; $display("FAIL rst_rgb got=%0d want=0", pix_rgb); end
    endtask

    task automatic test_lock();
        int  n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < HT * VT) begin
            tick();
            n++;
            total++;
            if (sync_err !== 1'b0) begin bad++; $display("FAIL lock_err got=%b want=0 at %0d,%0d", sync_err, s_h, s_v); end
            if (locked === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL lock_timeout got=0 want=1"); end
        total++;
        if (s_h != 0 || s_v != VD + VF) begin bad++; $display("FAIL lock_pos got=%0d,%0d want=0,%0d", s_h, s_v, VD + VF); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL lock_cnt got=%0d want=0", err_cnt); end
    endtask

    task automatic test_frames();
        int nv;
        int nfs;
        int lx;
        int ly;
        wait_gen(0, 0);
        for (int f = 0; f < 2; f++) begin
            nv = 0; nfs = 0; lx = -1; ly = -1;
            for (int i = 0; i < HT * VT; i++) begin
                tick();
                total++;
                if (pix_valid !== (s_h < HD && s_v < VD)) begin bad++; $display("FAIL frm_valid got=%b at %0d,%0d", pix_valid, s_h, s_v); end
                total++;
                if (frame_start !== (s_h == 0 && s_v == 0)) begin bad++; $display("FAIL frm_fs got=%b at %0d,%0d", frame_start, s_h, s_v); end
                if (pix_valid === 1'b1) begin
                    nv++;
                    total++;
                    if (pix_x !== 10'(s_h) || pix_y !== 10'(s_v) || pix_rgb !== pix_x[2:0]) begin
                        bad++;
                        $display("FAIL frm_pix got=%0d,%0d,%0d want=%0d,%0d,%0d", pix_x, pix_y, pix_rgb, s_h, s_v, s_h % 8);
                    end
                    if (nv == 1) begin
                        total++;
                        if (pix_x !== 10'd0 || pix_y !== 10'd0) begin bad++; $display("FAIL frm_first got=%0d,%0d want=0,0", pix_x, pix_y); end
                    end
                    lx = int'(pix_x);
                    ly = int'(pix_y);
                end
                if (frame_start === 1'b1) nfs++;
            end
            total++; if (nv != HD * VD) begin bad++; $display("FAIL frm_count got=%0d want=%0d", nv, HD * VD); end
            total++; if (nfs != 1) begin bad++; $display("FAIL frm_starts got=%0d want=1", nfs); end
            total++; if (lx != HD - 1 || ly != VD - 1) begin bad++; $display("FAIL frm_last got=%0d,%0d want=%0d,%0d", lx, ly, HD - 1, VD - 1); end
            total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL frm_cnt got=%0d want=0", err_cnt); end
        end
    endtask

    task automatic test_no_tick();
        repeat (3) tick();
        total++; if (pix_x !== 10'd2) begin bad++; $display("FAIL nt_pre got=%0d want=2", pix_x); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (pix_valid !== 1'b0 || frame_start !== 1'b0 || sync_err !== 1'b0) begin
                bad++;
                $display("FAIL nt_pulse got=%b%b%b want=000", pix_valid, frame_start, sync_err);
            end
            total++;
            if (pix_x !== 10'd2 || locked !== 1'b1) begin bad++; $display("FAIL nt_hold got=%0d,%b want=2,1", pix_x, locked); end
        end
        tick();
        total++;
        if (pix_valid !== 1'b1 || pix_x !== 10'd3) begin bad++; $display("FAIL nt_resume got=%b,%0d want=1,3", pix_valid, pix_x); end
    endtask

    task automatic test_early_hsync();
        int n;
        int nerr;
        int nvld;
        wait_gen(HD + HF - 4, 2);
        inj_h = 1'b1;
        tick();
        inj_h = 1'b0;
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL eh_err got=%b want=1", sync_err); end
        total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL eh_cnt got=%0d want=1", err_cnt); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL eh_locked got=%b want=0", locked); end
        n = 0; nerr = 0; nvld = 0;
        while (locked !== 1'b1 && n < 2 * HT * VT) begin
            tick();
            n++;
            if (sync_err === 1'b1) nerr++;
            if (pix_valid === 1'b1) nvld++;
        end
        total++; if (nerr != 0) begin bad++; $display("FAIL eh_pulse got=%0d want=0", nerr); end
        total++; if (nvld != 0) begin bad++; $display("FAIL eh_valid got=%0d want=0", nvld); end
        total++;
        if (locked !== 1'b1 || s_h != 0 || s_v != VD + VF) begin
            bad++;
            $display("FAIL eh_relock got=%b@%0d,%0d want=1@0,%0d", locked, s_h, s_v, VD + VF);
        end
    endtask

    task automatic test_vsync_missing();
        logic exp;
        wait_gen(0, VD + VF - 1);
        sup_v = 1'b1;
        for (int i = 0; i < 3 * HT; i++) begin
            tick();
            exp = (s_h == 0 && s_v == VD + VF);
            total++;
            if (sync_err !== exp) begin bad++; $display("FAIL vm_err got=%b want=%b at %0d,%0d", sync_err, exp, s_h, s_v); end
            if (exp) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL vm_locked got=%b want=0", locked); end
            end
        end
        sup_v = 1'b0;
        total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL vm_cnt got=%0d want=2", err_cnt); end
        wait_gen(0, VD + VF);
        tick();
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL vm_relock got=%b want=1", locked); end
    endtask

    task automatic test_reset_mid();
        int  n;
        int  nvld;
        wait_gen(4, 3);
        do_reset();
        total++; if (pix_valid !== 1'b0 || frame_start !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("FAIL rm_pulse got=%b%b%b want=000", pix_valid, frame_start, sync_err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rm_locked got=%b want=0", locked); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rm_cnt got=%0d want=0", err_cnt); end
        total++; if (pix_x !== 10'd0 || pix_y !== 10'd0 || pix_rgb !== 3'd0) begin bad++; $display("FAIL rm_pix got=%0d,%0d,%0d want=0,0,0", pix_x, pix_y, pix_rgb); end
        n = 0; nvld = 0;
        while (locked !== 1'b1 && n < 2 * HT * VT) begin
            tick();
            n++;
            if (pix_valid === 1'b1) nvld++;
        end
        total++; if (nvld != 0) begin bad++; $display("FAIL rm_valid got=%0d want=0", nvld); end
        total++;
        if (locked !== 1'b1 || s_h != 0 || s_v != VD + VF) begin
            bad++;
            $display("FAIL rm_relock got=%b@%0d,%0d want=1@0,%0d", locked, s_h, s_v, VD + VF);
        end
    endtask

    task automatic test_saturate();
        int n;
        int pulses;
        n = 0; pulses = 0;
        ovr_h = 1'b1;
        while (pulses < 300 && n < 3000) begin
            inj_h = (n % 2 == 0);
            tick();
            n++;
            if (sync_err === 1'b1) begin
                pulses++;
                if (pulses == 100) begin
                    total++;
                    if (err_cnt !== 8'd100) begin bad++; $display("FAIL sat_mid got=%0d want=100", err_cnt); end
                end
            end
        end
        ovr_h = 1'b0;
        inj_h = 1'b0;
        total++; if (pulses != 300) begin bad++; $display("FAIL sat_pulses got=%0d want=300", pulses); end
        total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_frames();
        test_no_tick();
        test_early_hsync();
        test_vsync_missing();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
